// File: rtl/fifo_32to16_out_if.sv
// Bus bundle between the FWFT FIFO, the 32->16 splitter and the EZ-USB slave-FIFO write side.
interface fifo_32to16_out_if;
  logic [31:0] DI;
  logic        EMPTY_IN;
  logic        RDEN;
  logic [15:0] DO;
  logic        VALID;
  logic        READY;
  logic        PKTEND;

  modport master (
    input  DI, EMPTY_IN, READY,
    output RDEN, DO, VALID, PKTEND
  );

  modport slave (
    output DI, EMPTY_IN, READY,
    input  RDEN, DO, VALID, PKTEND
  );
endinterface

// File: rtl/fifo_32to16_out.sv
// Pops 32-bit FWFT words and emits them as two 16-bit valid/ready transfers,
// committing short USB packets with a one-cycle PKTEND after an idle timeout.
module fifo_32to16_out #(
  parameter int unsigned LSB_FIRST = 1,
  parameter int unsigned PKT_WORDS = 256,
  parameter int unsigned TIMEOUT   = 1000
) (
  input logic              CLK,
  input logic              reset,
  fifo_32to16_out_if.master bus
);

  localparam int unsigned PKT_W  = $clog2(PKT_WORDS + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [PKT_W-1:0]  PKT_LAST  = PKT_W'(PKT_WORDS - 1);
  localparam logic [IDLE_W-1:0] IDLE_FIRE = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

  typedef enum logic [1:0] {S_EMPTY, S_FIRST, S_SECOND} state_t;

  state_t            state;
  logic [15:0]       hold_r;
  logic [15:0]       do_r;
  logic              valid_r;
  logic              pktend_r;
  logic [PKT_W-1:0]  pkt_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  logic        rden;
  logic        xfer;
  logic        fire;
  logic [15:0] first_half;
  logic [15:0] second_half;

  always_comb begin
    rden = !bus.EMPTY_IN && !reset &&
           ((state == S_EMPTY) || ((state == S_SECOND) && bus.READY));
    xfer = valid_r && bus.READY;
    fire = !valid_r && (pkt_cnt != '0) && (idle_cnt == IDLE_FIRE) && !rden;
    first_half  = (LSB_FIRST != 0) ? bus.DI[15:0]  : bus.DI[31:16];
    second_half = (LSB_FIRST != 0) ? bus.DI[31:16] : bus.DI[15:0];
  end

  // Only the half still to be sent is kept; the first half goes straight to DO.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= S_EMPTY;
      hold_r   <= '0;
      do_r     <= '0;
      valid_r  <= 1'b0;
      pktend_r <= 1'b0;
      pkt_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      pktend_r <= fire;

      if (rden) begin
        hold_r  <= second_half;
        do_r    <= first_half;
        valid_r <= 1'b1;
        state   <= S_FIRST;
      end else begin
        case (state)
          S_FIRST: if (xfer) begin
            do_r  <= hold_r;
            state <= S_SECOND;
          end
          S_SECOND: if (xfer) begin
            valid_r <= 1'b0;
            state   <= S_EMPTY;
          end
          default: ;
        endcase
      end

      if (xfer)
        pkt_cnt <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + 1'b1;
      else if (fire)
        pkt_cnt <= '0;

      // A stalled transfer (VALID high, READY low) is not idle time.
      if (xfer || rden || fire || pktend_r || (pkt_cnt == '0))
        idle_cnt <= '0;
      else if (!valid_r && (idle_cnt != IDLE_MAX))
        idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign bus.RDEN   = rden;
  assign bus.DO     = do_r;
  assign bus.VALID  = valid_r;
  assign bus.PKTEND = pktend_r;

endmodule

// File: tb/tb_fifo_32to16_out.sv
// Self-checking bench for fifo_32to16_out: directed vector table, hand sequences
// and randomized traffic against a half-word scoreboard with an idle-time model.
module tb_fifo_32to16_out;
  localparam int unsigned LSB_FIRST = 1;
  localparam int unsigned PKT_WORDS = 256;
  localparam int unsigned TIMEOUT   = 1000;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  fifo_32to16_out_if bus();

  fifo_32to16_out #(
    .LSB_FIRST(LSB_FIRST),
    .PKT_WORDS(PKT_WORDS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] src_q[$];
  logic [15:0] exp_q[$];
  int          hw_pending;
  int          m_pkt;
  int          quiet_run;
  int          cycle;
  int          n_xfer, n_pk, n_valid, n_rden;
  int          last_xfer_cyc, pk_cyc, first_valid, last_valid;
  int unsigned ready_pct, gap_pct;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [15:0] half(input logic [31:0] w, input int idx);
    if ((LSB_FIRST != 0) == (idx == 0)) return w[15:0];
    return w[31:16];
  endfunction

  task automatic model_clear();
    src_q.delete();
    exp_q.delete();
    hw_pending = 0; m_pkt = 0; quiet_run = 0;
    n_xfer = 0; n_pk = 0; n_valid = 0; n_rden = 0;
    last_xfer_cyc = -1; pk_cyc = -1; first_valid = -1; last_valid = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.EMPTY_IN = 1'b1;
    bus.READY = 1'b1;
    bus.DI = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_valid", bus.VALID, 1'b0);
    chk("reset_pktend", bus.PKTEND, 1'b0);
    chk("reset_do", bus.DO, 16'h0);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic drive();
    logic gate;
    gate = ($urandom_range(99) < gap_pct);
    bus.EMPTY_IN = (src_q.size() == 0) || gate;
    bus.DI = (src_q.size() != 0) ? src_q[0] : $urandom();
    bus.READY = ($urandom_range(99) < ready_pct);
  endtask

  // One clock: predict at the falling edge, compare after the rising edge.
  task automatic step();
    logic        e_rden, xfer, stall, quiet, e_pk;
    logic [15:0] do_before;
    logic [31:0] w;
    @(negedge CLK);
    e_rden = !bus.EMPTY_IN && ((hw_pending == 0) || ((hw_pending == 1) && bus.READY));
    chk("rden", bus.RDEN, e_rden);
    chk("valid", bus.VALID, hw_pending != 0);
    if (bus.VALID) begin
      n_valid++;
      if (first_valid < 0) first_valid = cycle;
      last_valid = cycle;
    end
    if (bus.RDEN) n_rden++;
    xfer  = (hw_pending != 0) && bus.READY;
    stall = (hw_pending != 0) && !bus.READY;
    if (xfer) begin
      if (exp_q.size() == 0) chk("scoreboard_underflow", 1'b1, 1'b0);
      else chk("do_data", bus.DO, exp_q.pop_front());
    end
    do_before = bus.DO;
    quiet = (hw_pending == 0) && !e_rden;
    e_pk  = quiet && (quiet_run + 1 == int'(TIMEOUT)) && (m_pkt != 0);
    @(posedge CLK);
    #1;
    cycle++;
    if (e_rden) begin
      w = src_q.pop_front();
      exp_q.push_back(half(w, 0));
      exp_q.push_back(half(w, 1));
    end
    hw_pending = hw_pending - (xfer ? 1 : 0) + (e_rden ? 2 : 0);
    if (xfer) begin
      m_pkt = (m_pkt + 1) % int'(PKT_WORDS);
      n_xfer++;
      last_xfer_cyc = cycle;
    end
    if (e_pk) begin
      m_pkt = 0;
      quiet_run = 0;
    end else if (quiet) quiet_run++;
    else quiet_run = 0;
    chk("pktend", bus.PKTEND, e_pk);
    if (bus.PKTEND) begin
      n_pk++;
      pk_cyc = cycle;
    end
    if (stall) chk("stall_do", bus.DO, do_before);
  endtask

  typedef struct {
    logic [31:0] di;
    logic        empty;
    logic        ready;
    logic        e_rden;
    logic        e_valid;
    logic        do_chk;
    logic [15:0] e_do;
  } vec_t;

  vec_t tbl[11];

  initial begin
    cycle = 0;
    ready_pct = 100;
    gap_pct = 0;
    reset = 1'b1;
    bus.DI = '0;
    bus.EMPTY_IN = 1'b1;
    bus.READY = 1'b0;

    // di, empty, ready -> rden, valid, check DO, DO
    tbl[0]  = '{32'h11112222, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h2222};
    tbl[1]  = '{32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1111};
    tbl[2]  = '{32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
    tbl[3]  = '{32'hAAAA5555, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h5555};
    tbl[4]  = '{32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5555};
    tbl[5]  = '{32'hCCCC3333, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5555};
    tbl[6]  = '{32'hCCCC3333, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hAAAA};
    tbl[7]  = '{32'hCCCC3333, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hAAAA};
    tbl[8]  = '{32'hCCCC3333, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h3333};
    tbl[9]  = '{32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'hCCCC};
    tbl[10] = '{32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};

    // Directed vectors, including the basic 0x11112222 push
    do_reset();
    for (int i = 0; i < 11; i++) begin
      bus.DI = tbl[i].di;
      bus.EMPTY_IN = tbl[i].empty;
      bus.READY = tbl[i].ready;
      @(negedge CLK);
      chk($sformatf("tbl%0d_rden", i), bus.RDEN, tbl[i].e_rden);
      @(posedge CLK);
      #1;
      chk($sformatf("tbl%0d_valid", i), bus.VALID, tbl[i].e_valid);
      chk($sformatf("tbl%0d_pktend", i), bus.PKTEND, 1'b0);
      if (tbl[i].do_chk) chk($sformatf("tbl%0d_do", i), bus.DO, tbl[i].e_do);
    end

    // Reset while S_FIRST with READY low, then a clean restart
    do_reset();
    bus.DI = 32'hDEADBEEF; bus.EMPTY_IN = 1'b0; bus.READY = 1'b0;
    @(negedge CLK);
    chk("rst6_rden_pre", bus.RDEN, 1'b1);
    @(posedge CLK); #1;
    chk("rst6_do_first", bus.DO, 16'hBEEF);
    reset = 1'b1;
    @(negedge CLK);
    chk("rst6_rden_in_reset", bus.RDEN, 1'b0);
    @(posedge CLK); #1;
    chk("rst6_valid", bus.VALID, 1'b0);
    chk("rst6_pktend", bus.PKTEND, 1'b0);
    chk("rst6_do", bus.DO, 16'h0);
    reset = 1'b0;
    bus.DI = 32'h12345678; bus.READY = 1'b1;
    @(negedge CLK);
    chk("rst6_rden_post", bus.RDEN, 1'b1);
    @(posedge CLK); #1;
    chk("rst6_restart_lo", bus.DO, 16'h5678);
    chk("rst6_restart_valid", bus.VALID, 1'b1);
    bus.EMPTY_IN = 1'b1;
    @(posedge CLK); #1;
    chk("rst6_restart_hi", bus.DO, 16'h1234);
    @(posedge CLK); #1;
    chk("rst6_done_valid", bus.VALID, 1'b0);

    // Preloaded 8 words at full rate
    do_reset();
    ready_pct = 100; gap_pct = 0;
    for (int i = 0; i < 8; i++) src_q.push_back($urandom());
    for (int i = 0; i < 20; i++) begin
      drive();
      step();
    end
    chk("burst_valid_cycles", n_valid, 16);
    chk("burst_valid_span", last_valid - first_valid + 1, 16);
    chk("burst_rden_count", n_rden, 8);
    chk("burst_scoreboard_empty", exp_q.size(), 0);

    // Random READY and FIFO gaps over 10k words
    do_reset();
    begin
      int pushed = 0;
      logic done = 1'b0;
      ready_pct = 50; gap_pct = 20;
      for (int c = 0; c < 70000 && !done; c++) begin
        if (src_q.size() < 4 && pushed < 10000) begin
          src_q.push_back($urandom());
          pushed++;
        end
        if (pushed == 10000) ready_pct = 75;
        drive();
        step();
        done = (pushed == 10000) && (src_q.size() == 0) && (hw_pending == 0);
      end
      chk("rand_drain_in_budget", done, 1'b1);
      chk("rand_xfer_count", n_xfer, 20000);
      chk("rand_scoreboard_empty", exp_q.size(), 0);
    end

    // Short packet: one PKTEND, TIMEOUT cycles after the last transfer
    do_reset();
    ready_pct = 100; gap_pct = 0;
    for (int i = 0; i < 3; i++) src_q.push_back($urandom());
    for (int i = 0; i < 1300; i++) begin
      drive();
      step();
    end
    chk("short_xfers", n_xfer, 6);
    chk("short_pktend_count", n_pk, 1);
    chk("short_pktend_delay", pk_cyc - last_xfer_cyc, TIMEOUT);

    // Exactly one full packet: no PKTEND
    do_reset();
    for (int i = 0; i < 128; i++) src_q.push_back($urandom());
    for (int i = 0; i < 5300; i++) begin
      drive();
      step();
    end
    chk("full_xfers", n_xfer, 256);
    chk("full_pktend_count", n_pk, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
